ps2_scancode_decoder: RTL and testbench

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 178 +++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode decoder.
// Turns the raw byte stream from a PS/2 controller into make/break key events.
// E0 (extended) and F0 (break) prefixes are folded into each event. A repeated
// make of the held key (typematic repeat) is suppressed. Events are queued in a
// 4-entry first-word fall-through FIFO.
//
// Ports:
//   CLOCK_50          in   clock, rising edge
//   reset             in   asynchronous active-high reset
//   received_data     in   [7:0] scancode byte
//   received_data_en  in   one-cycle strobe qualifying received_data
//   evt_valid         out  FIFO non-empty
//   evt_ready         in   consumer accepts the head event
//   evt_code          out  [7:0] head scancode (0 when empty)
//   evt_ext           out  head carried an E0 prefix
//   evt_release       out  head is a break
//   fifo_count        out  [2:0] queued events, 0..4
//   overflow          out  sticky: an event was dropped on a full FIFO
//
// state    | meaning
// IDLE     | no prefix pending
// GOT_E0   | E0 seen, waiting for code or F0
// GOT_F0   | F0 seen, next byte is a break code
// GOT_E0F0 | E0 F0 seen, next byte is an extended break code
module ps2_scancode_decoder (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_emit;
  logic        w_emit_ext;
  logic        w_emit_rel;
  logic        w_noise;
  logic        w_is_e0;
  logic        w_is_f0;

  logic        r_held_valid;
  logic        r_held_ext;
  logic [7:0]  r_held_code;
  logic        w_key_match;
  logic        w_push;

  logic [9:0]  r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_overflow;
  logic        w_pop;
  logic        w_full;
  logic        w_wr;
  logic [9:0]  w_head;

  assign w_is_e0 = (received_data == 8'hE0);
  assign w_is_f0 = (received_data == 8'hF0);

  // Controller status/response bytes that are never key codes when unprefixed.
  always_comb begin
    w_noise = 1'b0;
    case (received_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: w_noise = 1'b1;
      default:                                          w_noise = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_ext  = 1'b0;
    w_emit_rel  = 1'b0;
    if (received_data_en) begin
      case (r_state)
        IDLE: begin
          if (w_is_e0)       w_state_nxt = GOT_E0;
          else if (w_is_f0)  w_state_nxt = GOT_F0;
          else if (!w_noise) w_emit      = 1'b1;
        end
        GOT_E0: begin
          if (w_is_f0)       w_state_nxt = GOT_E0F0;
          else if (!w_is_e0) begin
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        GOT_F0: begin
          w_state_nxt = IDLE;
          if (!w_is_e0 && !w_is_f0) begin
            w_emit     = 1'b1;
            w_emit_rel = 1'b1;
          end
        end
        GOT_E0F0: begin
          w_state_nxt = IDLE;
          if (!w_is_e0 && !w_is_f0) begin
            w_emit     = 1'b1;
            w_emit_ext = 1'b1;
            w_emit_rel = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Typematic repeat: a make of the key already held down is not re-queued.
  assign w_key_match = (r_held_ext == w_emit_ext) && (r_held_code == received_data);
  assign w_push      = w_emit && (w_emit_rel || !(r_held_valid && w_key_match));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_held_valid <= 1'b0;
      r_held_ext   <= 1'b0;
      r_held_code  <= 8'h00;
    end else if (w_emit) begin
      if (!w_emit_rel && !(r_held_valid && w_key_match)) begin
        r_held_valid <= 1'b1;
        r_held_ext   <= w_emit_ext;
        r_held_code  <= received_data;
      end else if (w_emit_rel && w_key_match) begin
        r_held_valid <= 1'b0;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = evt_valid && evt_ready;
  assign w_full = (r_count == 3'd4);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 10'd0;
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {w_emit_ext, w_emit_rel, received_data};
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign evt_valid   = (r_count != 3'd0);
  assign evt_code    = evt_valid ? w_head[7:0] : 8'h00;
  assign evt_release = evt_valid & w_head[8];
  assign evt_ext     = evt_valid & w_head[9];
  assign fifo_count  = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic [2:0] fifo_count;
  logic       overflow;

  ps2_scancode_decoder dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .evt_code         (evt_code),
    .evt_ext          (evt_ext),
    .evt_release      (evt_release),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: prefix flags, held key, and the expected FIFO as a queue.
  bit         m_e0, m_f0;
  bit         m_hv, m_hext;
  logic [7:0] m_hcode;
  int         cur_cnt = 0, pend_cnt = 0;
  bit         cur_ovf = 0, pend_ovf = 0;
  logic [9:0] exp_q[$];

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit is_noise(logic [7:0] d);
    return d inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic void model_clear();
    m_e0 = 0; m_f0 = 0; m_hv = 0; m_hext = 0; m_hcode = 8'h00;
    cur_cnt = 0; pend_cnt = 0; cur_ovf = 0; pend_ovf = 0;
    exp_q.delete();
  endfunction

  // One clock: drive inputs just after the edge, predict what the next edge does.
  task automatic step(input bit en, input logic [7:0] d, input bit rdy);
    bit         em;
    bit         pop;
    logic [9:0] ev;
    @(posedge clk); #1;
    cur_cnt = pend_cnt;
    cur_ovf = pend_ovf;
    received_data_en = en;
    received_data    = d;
    evt_ready        = rdy;
    em = 0;
    ev = 10'd0;
    if (en) begin
      if (d == 8'hE0 || d == 8'hF0) begin
        if (m_f0) begin m_e0 = 0; m_f0 = 0; end
        else if (d == 8'hE0) m_e0 = 1;
        else m_f0 = 1;
      end else begin
        if (m_e0 || m_f0 || !is_noise(d)) begin
          em = 1;
          ev = {m_e0, m_f0, d};
        end
        m_e0 = 0; m_f0 = 0;
      end
    end
    if (em) begin
      if (!ev[8]) begin
        if (m_hv && m_hext == ev[9] && m_hcode == ev[7:0]) em = 0;
        else begin m_hv = 1; m_hext = ev[9]; m_hcode = ev[7:0]; end
      end else if (m_hext == ev[9] && m_hcode == ev[7:0]) begin
        m_hv = 0;
      end
    end
    pop      = (cur_cnt > 0) && rdy;
    pend_cnt = cur_cnt - (pop ? 1 : 0);
    pend_ovf = cur_ovf;
    if (em) begin
      if (cur_cnt < 4 || pop) begin
        exp_q.push_back(ev);
        pend_cnt++;
      end else begin
        pend_ovf = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; received_data_en = 0; evt_ready = 0;
    model_clear();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    step(1, d, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy);
  endtask

  // Monitor: outputs at the falling edge reflect the last rising edge.
  always @(negedge clk) begin
    logic [9:0] e;
    chk("fifo_count", int'(fifo_count), cur_cnt);
    chk("overflow", int'(overflow), int'(cur_ovf));
    chk("evt_valid", int'(evt_valid), int'(cur_cnt != 0));
    if (!evt_valid)
      chk("empty_head", int'({evt_ext, evt_release, evt_code}), 0);
    if (evt_valid && evt_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event actual=0x%0h expected=none at %0t",
                 {evt_ext, evt_release, evt_code}, $time);
      end else begin
        e = exp_q.pop_front();
        chk("event", int'({evt_ext, evt_release, evt_code}), int'(e));
      end
    end
  end

  logic [7:0] pool [8];

  initial begin
    reset = 1; received_data = 8'h00; received_data_en = 0; evt_ready = 0;
    model_clear();
    @(posedge clk); #1;
    reset = 0;

    // Make then break of 0x16
    send(8'h16, 1); idle(2, 1); send(8'hF0, 1); send(8'h16, 1); idle(3, 1);
    // Extended make/break, then status bytes only
    send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    send(8'hAA, 1); send(8'hFA, 1); idle(3, 1);
    // Typematic repeat suppression
    send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
    send(8'h1C, 1); idle(3, 1);
    // Overflow with consumer stalled, then drain
    send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0); send(8'h2E, 0);
    idle(2, 0);
    chk("ovf_full_count", int'(fifo_count), 4);
    chk("ovf_sticky", int'(overflow), 1);
    idle(6, 1);
    // Full FIFO with simultaneous pop and push
    do_reset();
    send(8'h16, 0); send(8'h1E, 0); send(8'h26, 0); send(8'h25, 0); send(8'h2E, 1);
    idle(2, 0);
    chk("full_pop_push_count", int'(fifo_count), 4);
    chk("full_pop_push_ovf", int'(overflow), 0);
    idle(6, 1);
    // Reset discards a pending prefix
    send(8'hE0, 0); do_reset(); send(8'h75, 1); idle(3, 1);

    // Randomized traffic
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C; pool[3] = 8'h16;
    pool[4] = 8'h75; pool[5] = 8'hAA; pool[6] = 8'hFA; pool[7] = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      if ($urandom_range(0, 199) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) d = 8'($urandom);
      else d = pool[$urandom_range(0, 7)];
      step($urandom_range(0, 9) < 7, d, $urandom_range(0, 1) == 1);
    end
    idle(8, 1);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
